// File: rtl/bus_conv_pkg.sv
// Shared definitions for the host-to-memory width converter.
//  - state_t    : FSM state type; the codes are also visible on the outstate debug port
//  - lane_sel_t : result of next_lane (found flag + lane index)
//  - calc_ratio / calc_lw : derive lane count and lane-index width from the data widths
//  - next_lane  : lowest set mask bit at or above a start index
package bus_conv_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_WRITE = 4'd1,   // write lanes still pending
        ST_READ  = 4'd2,   // read lanes still being issued
        ST_DRAIN = 4'd3,   // all reads issued, captures outstanding
        ST_ACK   = 4'd4    // bus_ack cycle
    } state_t;

    // Widest lane count supported; lane masks are zero-extended to this.
    localparam int MAX_RATIO = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } lane_sel_t;

    function automatic int calc_ratio(input int host_dw, input int mem_dw);
        return host_dw / mem_dw;
    endfunction

    function automatic int calc_lw(input int ratio);
        return $clog2(ratio);
    endfunction

    function automatic lane_sel_t next_lane(input logic [MAX_RATIO-1:0] mask,
                                            input logic [2:0]           from);
        lane_sel_t r;
        r = '0;
        // Descending scan so the lowest qualifying index is the last one written.
        for (int i = MAX_RATIO - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(from))) begin
                r.found = 1'b1;
                r.idx   = 3'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_conv_if.sv
// Host-side bus of the width converter.
//  master : host (drives en/we/addr/bytesel/data_in, receives data_out/bus_ack/busy)
//  slave  : converter
//  addr is a host word address (AW-LW bits); bytesel has one bit per memory lane.
interface bus_conv_if import bus_conv_pkg::*; #(
    parameter int AW      = 14,
    parameter int HOST_DW = 16,
    parameter int MEM_DW  = 8
);
    localparam int RATIO = calc_ratio(HOST_DW, MEM_DW);
    localparam int LW    = calc_lw(RATIO);

    logic                en;
    logic                we;
    logic [AW-LW-1:0]    addr;
    logic [RATIO-1:0]    bytesel;
    logic [HOST_DW-1:0]  data_in;
    logic [HOST_DW-1:0]  data_out;
    logic                bus_ack;
    logic                busy;

    modport master (
        output en, we, addr, bytesel, data_in,
        input  data_out, bus_ack, busy
    );

    modport slave (
        input  en, we, addr, bytesel, data_in,
        output data_out, bus_ack, busy
    );
endinterface

// File: rtl/bus_conv_lane_pick.sv
// Combinational priority picker: lowest set bit of the remaining-lane mask.
//  mask  in  RATIO  lanes still to be visited
//  found out 1      at least one lane remains
//  lane  out LW     index of the lowest remaining lane (0 when none)
module bus_conv_lane_pick import bus_conv_pkg::*; #(
    parameter int RATIO = 2,
    parameter int LW    = 1
) (
    input  logic [RATIO-1:0] mask,
    output logic             found,
    output logic [LW-1:0]    lane
);
    logic [MAX_RATIO-1:0] mask_ext;
    lane_sel_t            pick;
    logic                 unused_idx_bits;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_RATIO; gi++) begin : g_ext
            if (gi < RATIO) begin : g_used
                assign mask_ext[gi] = mask[gi];
            end else begin : g_pad
                assign mask_ext[gi] = 1'b0;
            end
        end
    endgenerate

    assign pick            = next_lane(mask_ext, 3'd0);
    assign found           = pick.found;
    assign lane            = pick.idx[LW-1:0];
    // Upper index bits are always zero when RATIO < MAX_RATIO.
    assign unused_idx_bits = ^pick.idx;
endmodule

// File: rtl/bus_width_converter.sv
// Host-to-memory width converter: one HOST_DW host access becomes one MEM_DW
// memory access per selected lane (ascending, unselected lanes skipped).
// Reads are issued back to back; an RD_LAT-deep valid/lane line tracks when
// each lane's data returns on mem_data_in.
//  clk, rst      clock / asynchronous active-low reset
//  host          host bus (slave side)
//  mem_addr      {latched word address, lane}
//  mem_data_in   RAM read data, RD_LAT cycles after mem_en
//  mem_data_out  RAM write data
//  mem_we/mem_en RAM write strobe / enable
//  outstate      current FSM state code
// All outputs are registered.
module bus_width_converter import bus_conv_pkg::*; #(
    parameter int AW      = 14,
    parameter int HOST_DW = 16,
    parameter int MEM_DW  = 8,
    parameter int RD_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    bus_conv_if.slave         host,
    output logic [AW-1:0]     mem_addr,
    input  logic [MEM_DW-1:0] mem_data_in,
    output logic [MEM_DW-1:0] mem_data_out,
    output logic              mem_we,
    output logic              mem_en,
    output logic [3:0]        outstate
);
    localparam int RATIO = calc_ratio(HOST_DW, MEM_DW);
    localparam int LW    = calc_lw(RATIO);

    generate
        if (HOST_DW % MEM_DW != 0) begin : g_bad_dw
            $error("HOST_DW must be a multiple of MEM_DW");
        end
        if (RATIO < 2 || RATIO > MAX_RATIO || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
            $error("HOST_DW/MEM_DW must be a power of two in 2..8");
        end
        if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
            $error("RD_LAT must be in 1..4");
        end
    endgenerate

    state_t              state_reg, state_next;
    logic                armed_reg;
    logic                we_reg;
    logic [AW-LW-1:0]    addr_reg;
    logic [HOST_DW-1:0]  wdata_reg;
    logic [RATIO-1:0]    pend_reg, pend_next;
    logic [HOST_DW-1:0]  cap_reg, cap_merged;
    logic [RD_LAT:0]     cap_vld_reg;
    logic [LW-1:0]       cap_lane_reg [RD_LAT+1];
    logic [HOST_DW-1:0]  data_out_reg, data_out_next;
    logic                mem_en_reg, mem_en_next;
    logic                mem_we_reg, mem_we_next;
    logic [AW-1:0]       mem_addr_reg, mem_addr_next;
    logic [MEM_DW-1:0]   mem_dout_reg, mem_dout_next;
    logic                bus_ack_reg, bus_ack_next;
    logic                busy_reg, busy_next;

    logic                accept, in_issue_state, issue, last_capture;
    logic                we_src;
    logic [AW-LW-1:0]    addr_src;
    logic [HOST_DW-1:0]  wdata_src;
    logic [RATIO-1:0]    pick_mask, lane_onehot;
    logic                pick_found;
    logic [LW-1:0]       pick_lane;
    logic [MEM_DW-1:0]   wr_lane [RATIO];

    assign accept         = (state_reg == ST_IDLE) && host.en && armed_reg;
    assign in_issue_state = (state_reg == ST_WRITE) || (state_reg == ST_READ);

    // On the accepting edge the first lane is issued straight from the host
    // inputs so that memory activity starts in the very next cycle.
    assign pick_mask = (state_reg == ST_IDLE) ? host.bytesel : pend_reg;
    assign we_src    = accept ? host.we      : we_reg;
    assign addr_src  = accept ? host.addr    : addr_reg;
    assign wdata_src = accept ? host.data_in : wdata_reg;

    bus_conv_lane_pick #(.RATIO(RATIO), .LW(LW)) u_lane_pick (
        .mask  (pick_mask),
        .found (pick_found),
        .lane  (pick_lane)
    );

    assign issue = pick_found && (accept || in_issue_state);

    genvar gi;
    generate
        for (gi = 0; gi < RATIO; gi++) begin : g_lane
            assign wr_lane[gi]     = wdata_src[gi*MEM_DW +: MEM_DW];
            assign lane_onehot[gi] = (pick_lane == LW'(gi));
            // Capture register with the lane returning this cycle already merged in.
            assign cap_merged[gi*MEM_DW +: MEM_DW] =
                (cap_vld_reg[RD_LAT] && cap_lane_reg[RD_LAT] == LW'(gi)) ?
                mem_data_in : cap_reg[gi*MEM_DW +: MEM_DW];
        end
    endgenerate

    assign pend_next = (accept || in_issue_state) ? (pick_mask & ~lane_onehot) : pend_reg;

    // Last read returns when the oldest stage is valid and nothing younger is in flight.
    assign last_capture = (state_reg == ST_DRAIN) && cap_vld_reg[RD_LAT] &&
                          !(|cap_vld_reg[RD_LAT-1:0]);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (!pick_found)  state_next = ST_ACK;
                    else if (host.we) state_next = ST_WRITE;
                    else              state_next = ST_READ;
                end
            end
            ST_WRITE: if (!pick_found) state_next = ST_ACK;
            ST_READ:  if (!pick_found) state_next = ST_DRAIN;
            ST_DRAIN: if (last_capture) state_next = ST_ACK;
            ST_ACK:   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_en_next   = issue;
        mem_we_next   = issue && we_src;
        mem_addr_next = '0;
        mem_dout_next = '0;
        if (issue) begin
            mem_addr_next = {addr_src, pick_lane};
            if (we_src) mem_dout_next = wr_lane[pick_lane];
        end
        bus_ack_next  = (state_next == ST_ACK);
        busy_next     = (state_next != ST_IDLE);
        data_out_next = last_capture ? cap_merged : data_out_reg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            armed_reg    <= 1'b1;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            pend_reg     <= '0;
            cap_reg      <= '0;
            cap_vld_reg  <= '0;
            for (int s = 0; s <= RD_LAT; s++) cap_lane_reg[s] <= '0;
            data_out_reg <= '0;
            mem_en_reg   <= 1'b0;
            mem_we_reg   <= 1'b0;
            mem_addr_reg <= '0;
            mem_dout_reg <= '0;
            bus_ack_reg  <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            // A held-high en must drop for a cycle before the next acceptance.
            if (accept)        armed_reg <= 1'b0;
            else if (!host.en) armed_reg <= 1'b1;
            if (accept) begin
                we_reg    <= host.we;
                addr_reg  <= host.addr;
                wdata_reg <= host.data_in;
            end
            pend_reg        <= pend_next;
            cap_vld_reg     <= {cap_vld_reg[RD_LAT-1:0], issue && !we_src};
            cap_lane_reg[0] <= pick_lane;
            for (int s = 1; s <= RD_LAT; s++) cap_lane_reg[s] <= cap_lane_reg[s-1];
            // Cleared per transaction so unselected lanes read back as zero.
            if (accept)                   cap_reg <= '0;
            else if (cap_vld_reg[RD_LAT]) cap_reg <= cap_merged;
            data_out_reg <= data_out_next;
            mem_en_reg   <= mem_en_next;
            mem_we_reg   <= mem_we_next;
            mem_addr_reg <= mem_addr_next;
            mem_dout_reg <= mem_dout_next;
            bus_ack_reg  <= bus_ack_next;
            busy_reg     <= busy_next;
        end
    end

    assign host.data_out = data_out_reg;
    assign host.bus_ack  = bus_ack_reg;
    assign host.busy     = busy_reg;
    assign mem_en        = mem_en_reg;
    assign mem_we        = mem_we_reg;
    assign mem_addr      = mem_addr_reg;
    assign mem_data_out  = mem_dout_reg;
    assign outstate      = state_reg;
endmodule

// File: tb/tb_bus_width_converter.sv
// Bench for bus_width_converter: DUT A (16/8, RD_LAT=1) and DUT B (32/8, RD_LAT=2),
// each with a byte-wide RAM model of matching latency.
module tb_bus_width_converter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bus_conv_if #(.AW(14), .HOST_DW(16), .MEM_DW(8)) host_a ();
    bus_conv_if #(.AW(14), .HOST_DW(32), .MEM_DW(8)) host_b ();

    logic [13:0] a_mem_addr, b_mem_addr;
    logic [7:0]  a_mem_din, a_mem_dout, b_mem_din, b_mem_dout;
    logic        a_mem_we, a_mem_en, b_mem_we, b_mem_en;
    logic [3:0]  a_outstate, b_outstate;

    bus_width_converter #(.AW(14), .HOST_DW(16), .MEM_DW(8), .RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .host(host_a),
        .mem_addr(a_mem_addr), .mem_data_in(a_mem_din), .mem_data_out(a_mem_dout),
        .mem_we(a_mem_we), .mem_en(a_mem_en), .outstate(a_outstate)
    );

    bus_width_converter #(.AW(14), .HOST_DW(32), .MEM_DW(8), .RD_LAT(2)) dut_b (
        .clk(clk), .rst(rst), .host(host_b),
        .mem_addr(b_mem_addr), .mem_data_in(b_mem_din), .mem_data_out(b_mem_dout),
        .mem_we(b_mem_we), .mem_en(b_mem_en), .outstate(b_outstate)
    );

    // RAM models; read data is only meaningful in its return cycle, otherwise a marker byte.
    logic [7:0] ram_a [16384];
    logic [7:0] ram_b [16384];
    logic [7:0] rda_q, rdb_q1, rdb_q2;
    logic       rda_v = 1'b0, rdb_v1 = 1'b0, rdb_v2 = 1'b0;

    always @(posedge clk) begin
        if (a_mem_en && a_mem_we) ram_a[a_mem_addr] <= a_mem_dout;
        rda_v <= a_mem_en && !a_mem_we;
        rda_q <= ram_a[a_mem_addr];
        if (b_mem_en && b_mem_we) ram_b[b_mem_addr] <= b_mem_dout;
        rdb_v1 <= b_mem_en && !b_mem_we;
        rdb_q1 <= ram_b[b_mem_addr];
        rdb_v2 <= rdb_v1;
        rdb_q2 <= rdb_q1;
    end
    assign a_mem_din = rda_v  ? rda_q  : 8'hC3;
    assign b_mem_din = rdb_v2 ? rdb_q2 : 8'hC3;

    // Observation mux onto whichever DUT the current sequence targets.
    logic        tsel = 1'b0;
    logic        m_en, m_we, m_ack, m_busy;
    logic [13:0] m_addr;
    logic [7:0]  m_dout;
    logic [31:0] m_hdout;
    logic [3:0]  m_state;
    always_comb begin
        m_en    = tsel ? b_mem_en        : a_mem_en;
        m_we    = tsel ? b_mem_we        : a_mem_we;
        m_addr  = tsel ? b_mem_addr      : a_mem_addr;
        m_dout  = tsel ? b_mem_dout      : a_mem_dout;
        m_ack   = tsel ? host_b.bus_ack  : host_a.bus_ack;
        m_busy  = tsel ? host_b.busy     : host_a.busy;
        m_hdout = tsel ? host_b.data_out : {16'h0, host_a.data_out};
        m_state = tsel ? b_outstate      : a_outstate;
    end

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          sel;
        bit          we;
        logic [12:0] addr;
        logic [3:0]  bsel;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input bit en, input bit we, input logic [12:0] addr,
                         input logic [3:0] bsel, input logic [31:0] wdata);
        if (!sel) begin
            host_a.en = en; host_a.we = we; host_a.addr = addr;
            host_a.bytesel = bsel[1:0]; host_a.data_in = wdata[15:0];
        end else begin
            host_b.en = en; host_b.we = we; host_b.addr = addr[11:0];
            host_b.bytesel = bsel; host_b.data_in = wdata;
        end
    endtask

    function automatic int nth_lane(input logic [3:0] m, input int n);
        int c = 0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                if (c == n) return i;
                c++;
            end
        end
        return -1;
    endfunction

    task automatic do_txn(input int idx, input vec_t v);
        int ack_k, nacc, lane, st1, st_ack, busy_bad, seq_bad, exp_st1;
        logic [13:0] exp_addr;
        logic [7:0]  exp_byte;
        logic [31:0] rd_val;
        tsel = v.sel;
        ack_k = -1; nacc = 0; st1 = -1; st_ack = -1; busy_bad = 0; seq_bad = 0; rd_val = '0;
        exp_st1 = (v.bsel == 4'b0) ? 4 : (v.we ? 1 : 2);
        @(negedge clk);
        drive(v.sel, 1'b1, v.we, v.addr, v.bsel, v.wdata);
        for (int k = 1; k <= 40 && ack_k < 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                st1 = int'(m_state);
                // Garbage on the host bus while busy must be ignored.
                drive(v.sel, 1'b0, ~v.we, ~v.addr, ~v.bsel, ~v.wdata);
            end
            if (!m_busy) busy_bad++;
            if (m_en) begin
                lane     = nth_lane(v.bsel, nacc);
                exp_addr = v.sel ? {v.addr[11:0], 2'(lane)} : {v.addr, 1'(lane)};
                exp_byte = v.we ? 8'(v.wdata >> (8 * lane)) : 8'h00;
                if (lane < 0 || k != nacc + 1 || m_we !== v.we ||
                    m_addr !== exp_addr || m_dout !== exp_byte) seq_bad++;
                nacc++;
            end
            if (m_ack) begin
                ack_k  = k;
                st_ack = int'(m_state);
                rd_val = m_hdout;
            end
        end
        check("ack_latency", ack_k, v.exp_lat);
        check("mem_count", nacc, $countones(v.bsel));
        check("mem_seq_errors", seq_bad, 0);
        check("busy_gaps", busy_bad, 0);
        check("state_first", st1, exp_st1);
        check("state_ack", st_ack, 4);
        if (!v.we) check("read_data", rd_val, v.exp_rdata);
        @(negedge clk);
        check("idle_after", {m_ack, m_busy, m_state}, 0);
        $display("txn %0d dut=%0d we=%0d addr=0x%0h bsel=%b ack_lat=%0d data_out=0x%0h",
                 idx, v.sel, v.we, v.addr, v.bsel, ack_k, rd_val);
    endtask

    initial begin
        int acks;
        logic mem_seen;
        vec_t rv;

        vecs = '{
            '{1'b0, 1'b1, 13'd5,    4'b0011, 32'h0000AABB, 32'h0,        3},
            '{1'b0, 1'b0, 13'd5,    4'b0011, 32'h0,        32'h0000AABB, 4},
            '{1'b0, 1'b1, 13'd5,    4'b0010, 32'h00001234, 32'h0,        2},
            '{1'b0, 1'b0, 13'd5,    4'b0011, 32'h0,        32'h000012BB, 4},
            '{1'b0, 1'b0, 13'd5,    4'b0001, 32'h0,        32'h000000BB, 3},
            '{1'b0, 1'b0, 13'd5,    4'b0000, 32'h0,        32'h000000BB, 1},
            '{1'b0, 1'b1, 13'h1FFF, 4'b0011, 32'h00005566, 32'h0,        3},
            '{1'b0, 1'b0, 13'h1FFF, 4'b0011, 32'h0,        32'h00005566, 4},
            '{1'b1, 1'b1, 13'd3,    4'b1111, 32'hDEADBEEF, 32'h0,        5},
            '{1'b1, 1'b0, 13'd3,    4'b1111, 32'h0,        32'hDEADBEEF, 7},
            '{1'b1, 1'b0, 13'd3,    4'b0101, 32'h0,        32'h00AD00EF, 5},
            '{1'b1, 1'b1, 13'd3,    4'b1010, 32'h11223344, 32'h0,        3},
            '{1'b1, 1'b0, 13'd3,    4'b1111, 32'h0,        32'h11AD33EF, 7}
        };

        drive(1'b0, 1'b0, 1'b0, 13'd0, 4'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 13'd0, 4'd0, 32'd0);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_a_mem",  {a_mem_en, a_mem_we, a_mem_addr, a_mem_dout}, 0);
        check("rst_a_host", {host_a.bus_ack, host_a.busy, host_a.data_out, a_outstate}, 0);
        check("rst_b_mem",  {b_mem_en, b_mem_we, b_mem_addr, b_mem_dout}, 0);
        check("rst_b_host", {host_b.bus_ack, host_b.busy, host_b.data_out, b_outstate}, 0);
        rst = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) do_txn(i, vecs[i]);

        // en held high: one transaction only, re-arm after en low for one cycle.
        tsel = 1'b0;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 13'd5, 4'b0000, 32'hFFFF);
        acks = 0;
        mem_seen = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            acks += int'(m_ack);
            mem_seen |= m_en;
            if (k == 3) check("hold_idle_state", m_state, 0);
            if (k == 6) drive(1'b0, 1'b0, 1'b1, 13'd5, 4'b0000, 32'hFFFF);
        end
        check("hold_ack_count", acks, 1);
        check("hold_mem_en", mem_seen, 0);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 13'd5, 4'b0000, 32'hFFFF);
        @(negedge clk);
        check("rearm_ack", {m_ack, m_en}, 2'b10);
        drive(1'b0, 1'b0, 1'b1, 13'd5, 4'b0000, 32'hFFFF);
        @(negedge clk);
        check("rearm_single_ack", m_ack, 0);
        $display("txn hold dut=0 acks_in_hold=%0d", acks);

        // Reset during second read lane.
        tsel = 1'b0;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 13'd5, 4'b0011, 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 13'd5, 4'b0011, 32'd0);
        @(negedge clk);
        check("pre_reset_lane1", {m_en, m_addr}, {1'b1, 14'd11});
        rst = 1'b0;
        #1;
        check("reset_mem_outs",  {a_mem_en, a_mem_we, a_mem_addr, a_mem_dout}, 0);
        check("reset_host_outs", {host_a.bus_ack, host_a.busy, host_a.data_out, a_outstate}, 0);
        @(negedge clk);
        rst = 1'b1;
        acks = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            acks += int'(m_ack) + int'(m_busy) + int'(m_state != 4'd0);
        end
        check("no_ack_after_reset", acks, 0);
        $display("txn reset_abort dut=0 activity_after=%0d", acks);
        rv = '{1'b0, 1'b0, 13'd5, 4'b0011, 32'h0, 32'h000012BB, 4};
        do_txn(100, rv);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
